// File: rtl/card_pkg.sv
// card_pkg: shared constants, state encoding and count type for the card dealer
package card_pkg;
   localparam int CARD_W      = 4;
   localparam int MAX_VAL_DEF = 10;
   localparam int COPIES_DEF  = 2;
   localparam int DECK_SIZE   = MAX_VAL_DEF * COPIES_DEF;
   typedef logic [2:0] state_t;
   typedef logic [1:0] cnt_t;
   localparam state_t S_IDLE = 3'd0;
   localparam state_t S_REQ  = 3'd1;
   localparam state_t S_WAIT = 3'd2;
   localparam state_t S_CHK  = 3'd3;
   localparam state_t S_DONE = 3'd4;
endpackage

// File: rtl/card_pick_lowest.sv
// card_pick_lowest: lowest card value that still has copies left in the deck
module card_pick_lowest
   import card_pkg::*;
#(
   parameter int MAX_VAL = MAX_VAL_DEF
) (
   input  cnt_t [MAX_VAL:1]   cnt,
   output logic [CARD_W-1:0] low,
   output logic              any
);
   // scan from the top so the smallest available value wins
   always_comb begin
      low = '0;
      for (int v = MAX_VAL; v >= 1; v--)
         if (cnt[v] != 2'd0) low = CARD_W'(v);
      any = low != '0;
   end
endmodule

// File: rtl/card_deal_ctrl.sv
// card_deal_ctrl: sequences the random generator and deals one card per player
module card_deal_ctrl
   import card_pkg::*;
#(
   parameter int MAX_VAL   = MAX_VAL_DEF,
   parameter int COPIES    = COPIES_DEF,
   parameter int EN_CYCLES = 2,
   parameter int SETTLE    = 1,
   parameter int MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              deal,
   input  logic              new_deck,
   input  logic [CARD_W-1:0] rnd,
   output logic              rnd_en,
   output logic [CARD_W-1:0] card_a,
   output logic [CARD_W-1:0] card_b,
   output logic              cards_valid,
   output logic              busy,
   output logic              deck_empty,
   output logic [4:0]        cards_left
);
   localparam int TW = $clog2(MAX_TRIES);
   localparam logic [4:0] FULL = 5'(MAX_VAL * COPIES);
   state_t              state;
   logic                side;
   logic [TW-1:0]       tries;
   logic [3:0]          ctr;
   cnt_t [MAX_VAL:1]    cnt;
   logic [15:0]         avail;
   logic [CARD_W-1:0]   low;
   logic [CARD_W-1:0]   val;
   logic                any;
   logic                take;
   card_pick_lowest #(.MAX_VAL(MAX_VAL)) u_pick (
      .cnt (cnt),
      .low (low),
      .any (any)
   );
   // availability mask indexed directly by the raw draw; 0 and values above MAX_VAL stay clear
   always_comb begin
      avail = '0;
      for (int v = 1; v <= MAX_VAL; v++) avail[v] = cnt[v] != 2'd0;
   end
   assign take = avail[rnd] || tries == TW'(MAX_TRIES - 1);
   assign val  = avail[rnd] ? rnd : low;
   // dealer sequencer: draw request, settle, check, then hand out both cards
   always_ff @(posedge clk) begin
      if (!clr) begin
         state       <= S_IDLE;
         side        <= 1'b0;
         tries       <= '0;
         ctr         <= '0;
         rnd_en      <= 1'b0;
         card_a      <= '0;
         card_b      <= '0;
         cards_valid <= 1'b0;
         busy        <= 1'b0;
         cards_left  <= FULL;
         deck_empty  <= 1'b0;
         for (int v = 1; v <= MAX_VAL; v++) cnt[v] <= cnt_t'(COPIES);
      end else begin
         case (state)
            S_IDLE: begin
               if (new_deck) begin
                  for (int v = 1; v <= MAX_VAL; v++) cnt[v] <= cnt_t'(COPIES);
                  cards_left  <= FULL;
                  deck_empty  <= 1'b0;
                  cards_valid <= 1'b0;
               end else if (deal && !deck_empty) begin
                  cards_valid <= 1'b0;
                  side        <= 1'b0;
                  tries       <= '0;
                  ctr         <= '0;
                  rnd_en      <= 1'b1;
                  busy        <= 1'b1;
                  state       <= S_REQ;
               end
            end
            S_REQ: begin
               ctr <= ctr == 4'(EN_CYCLES - 1) ? 4'd0 : ctr + 4'd1;
               if (ctr == 4'(EN_CYCLES - 1)) begin
                  rnd_en <= 1'b0;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               ctr <= ctr == 4'(SETTLE - 1) ? 4'd0 : ctr + 4'd1;
               if (ctr == 4'(SETTLE - 1)) state <= S_CHK;
            end
            S_CHK: begin
               if (take) begin
                  for (int v = 1; v <= MAX_VAL; v++)
                     if (val == CARD_W'(v)) cnt[v] <= cnt[v] - 2'd1;
                  cards_left <= cards_left - 5'd1;
                  deck_empty <= cards_left == 5'd1;
                  if (side) begin
                     card_b <= val;
                     state  <= S_DONE;
                  end else begin
                     card_a <= val;
                     side   <= 1'b1;
                     tries  <= '0;
                     rnd_en <= 1'b1;
                     state  <= S_REQ;
                  end
               end else begin
                  tries  <= tries + 1'b1;
                  rnd_en <= 1'b1;
                  state  <= S_REQ;
               end
            end
            S_DONE: begin
               cards_valid <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
   // the empty flag must agree with the per-value counts at every edge
   assert property (@(posedge clk) disable iff (!clr) deck_empty == !any);
endmodule
